// File: rtl/mdu_ctrl.sv
// mdu_ctrl: EX-stage multiply/divide sequencer owning HI/LO, with pipeline stall generation.
// Define MDU_DIV_EARLY_EN to finish divides with |a|<|b| (b nonzero) in a single busy cycle.
module mdu_ctrl #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mdu_op_i,
    input  logic        mdu_en_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic [31:0] result_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, DIV_SIGN} state_t;
    state_t state, state_n;
    logic [5:0]  cnt;
    logic [63:0] prod;
    logic        mul_blk;
    logic [31:0] quo, rem, dvs;
    logic        sa, sb;
    logic        op_valid, accept, is_div, is_mul, sdiv, sx, early;
    logic [31:0] a_mag, b_mag;
    logic [63:0] ext_a, ext_b;
    logic [32:0] rem_sh, diff;

    assign op_valid = mdu_en_i && mdu_op_i inside {[4'd1:4'd9]};
    assign accept   = state == IDLE && mdu_en_i && !flush_i;
    assign is_div   = mdu_op_i == 4'd1 || mdu_op_i == 4'd2;
    assign is_mul   = mdu_op_i inside {[4'd3:4'd5]};
    assign sdiv     = mdu_op_i == 4'd1;
    assign sx       = mdu_op_i != 4'd5;
    assign a_mag    = (sdiv && a_i[31]) ? -a_i : a_i;
    assign b_mag    = (sdiv && b_i[31]) ? -b_i : b_i;
    assign ext_a    = {{32{sx & a_i[31]}}, a_i};
    assign ext_b    = {{32{sx & b_i[31]}}, b_i};
    assign busy_o   = state != IDLE;
    // restoring step: shift next dividend bit into the partial remainder and try the subtract
    assign rem_sh   = {rem, quo[31]};
    assign diff     = rem_sh - {1'b0, dvs};
`ifdef MDU_DIV_EARLY_EN
    assign early    = b_mag != 32'd0 && a_mag < b_mag;
`else
    assign early    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_n;
    end

    always_comb begin
        state_n  = state;
        stall_o  = 1'b0;
        result_o = '0;
        case (state)
            IDLE: if (accept) begin
                state_n  = is_div ? (early ? DIV_SIGN : DIV_BUSY) : is_mul ? MUL_BUSY : IDLE;
                stall_o  = mdu_op_i == 4'd3;
                result_o = mdu_op_i == 4'd6 ? hi_o : mdu_op_i == 4'd7 ? lo_o : '0;
            end
            MUL_BUSY: begin
                state_n  = (flush_i || cnt == 6'd0) ? IDLE : MUL_BUSY;
                // the held MUL is released in its completion cycle and consumed there
                stall_o  = op_valid && !(mul_blk && cnt == 6'd0);
                result_o = (mul_blk && cnt == 6'd0 && !flush_i) ? prod[31:0] : '0;
            end
            DIV_BUSY: begin
                state_n = flush_i ? IDLE : (cnt == 6'd1 ? DIV_SIGN : DIV_BUSY);
                stall_o = op_valid;
            end
            default: begin
                state_n = IDLE;
                stall_o = op_valid;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_o    <= '0;
            lo_o    <= '0;
            cnt     <= '0;
            prod    <= '0;
            mul_blk <= 1'b0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
        end else if (accept) begin
            case (mdu_op_i)
                4'd1, 4'd2: begin
                    sa  <= sdiv && a_i[31];
                    sb  <= sdiv && b_i[31];
                    dvs <= b_mag;
                    rem <= early ? a_mag : '0;
                    quo <= early ? '0 : a_mag;
                    cnt <= 6'd32;
                end
                4'd3, 4'd4, 4'd5: begin
                    prod    <= ext_a * ext_b;
                    mul_blk <= mdu_op_i == 4'd3;
                    cnt     <= 6'(MUL_CYCLES - 1);
                end
                4'd8: hi_o <= a_i;
                4'd9: lo_o <= a_i;
                default: ;
            endcase
        end else if (!flush_i) begin
            if (state == MUL_BUSY) begin
                if (cnt == 6'd0) begin
                    if (!mul_blk) {hi_o, lo_o} <= prod;
                end else begin
                    cnt <= cnt - 6'd1;
                end
            end else if (state == DIV_BUSY) begin
                rem <= diff[32] ? rem_sh[31:0] : diff[31:0];
                quo <= {quo[30:0], ~diff[32]};
                cnt <= cnt - 6'd1;
            end else if (state == DIV_SIGN) begin
                lo_o <= (sa ^ sb) ? -quo : quo;
                hi_o <= sa ? -rem : rem;
            end
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed plus randomized checks of mdu_ctrl against an arithmetic reference.
module tb_mdu_ctrl;
    localparam int MC = 3;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  op = '0;
    logic        en = 1'b0, flush = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        stall, busy;
    logic [31:0] result, hi, lo;
    int          vec = 0, errs = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .rst_n(rst_n), .mdu_op_i(op), .mdu_en_i(en), .a_i(a), .b_i(b),
        .flush_i(flush), .stall_o(stall), .busy_o(busy), .result_o(result),
        .hi_o(hi), .lo_o(lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [3:0] o, input logic e, input logic [31:0] x, input logic [31:0] y);
        op = o; en = e; a = x; b = y;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    task automatic do_mul(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = (o == 4'd5) ? {32'b0, x} * {32'b0, y} : 64'(longint'($signed(x)) * longint'($signed(y)));
        set(o, 1'b1, x, y);
        @(negedge clk);
        chk("mul_stall_t", stall, o == 4'd3);
        step();
        if (o != 4'd3) en = 1'b0;
        for (int i = 1; i <= MC; i++) begin
            @(negedge clk);
            chk("mul_busy", busy, 1);
            chk("mul_stall", stall, (o == 4'd3) && (i < MC));
            if (o == 4'd3 && i == MC) chk("mul_result", result, p[31:0]);
            if (i == MC) en = 1'b0;
            step();
        end
        if (o != 4'd3) {m_hi, m_lo} = p;
        chk_idle("mul_done");
    endtask

    task automatic do_div(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic        sg;
        logic [31:0] am, bm, q, r;
        longint      qa, ra;
        int          n;
        sg = o == 4'd1;
        am = (sg && x[31]) ? -x : x;
        bm = (sg && y[31]) ? -y : y;
        if (y == 0) begin
            q = (sg && x[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = x;
        end else if (sg) begin
            qa = longint'($signed(x)) / longint'($signed(y));
            ra = longint'($signed(x)) % longint'($signed(y));
            q = qa[31:0];
            r = ra[31:0];
        end else begin
            q = x / y;
            r = x % y;
        end
        n = 33;
`ifdef MDU_DIV_EARLY_EN
        if (y != 0 && am < bm) n = 1;
`endif
        set(o, 1'b1, x, y);
        @(negedge clk);
        chk("div_stall_t", stall, 0);
        chk("div_busy_t", busy, 0);
        step();
        en = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            chk("div_busy", busy, 1);
            step();
        end
        m_lo = q;
        m_hi = r;
        chk_idle("div_done");
    endtask

    task automatic do_mv(input logic [3:0] o, input logic [31:0] x);
        set(o, 1'b1, x, 32'd0);
        @(negedge clk);
        chk("mv_stall", stall, 0);
        chk("mv_result", result, o == 4'd6 ? m_hi : o == 4'd7 ? m_lo : 32'd0);
        step();
        en = 1'b0;
        if (o == 4'd8) m_hi = x;
        if (o == 4'd9) m_lo = x;
        chk_idle("mv_done");
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] rx, ry;
        step();
        step();
        chk("rst_stall", stall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst_n = 1'b1;
        step();

        set(4'd5, 1'b1, 32'hFFFF_FFFF, 32'd2);
        @(negedge clk);
        chk("multu_stall_t", stall, 0);
        step();
        set(4'd6, 1'b1, 32'd0, 32'd0);
        for (int i = 1; i <= MC; i++) begin
            @(negedge clk);
            chk("mfhi_wait_stall", stall, 1);
            chk("mfhi_wait_busy", busy, 1);
            step();
        end
        m_hi = 32'd1;
        m_lo = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("mfhi_stall", stall, 0);
        chk("mfhi_result", result, 32'd1);
        chk("multu_hi", hi, m_hi);
        chk("multu_lo", lo, m_lo);
        step();
        en = 1'b0;

        do_mul(4'd4, 32'hFFFF_FFFF, 32'd2);
        do_mul(4'd3, 32'd6, 32'd7);
        do_mv(4'd6, 32'd0);
        do_mv(4'd7, 32'd0);
        do_div(4'd1, -32'sd7, 32'd2);
        do_div(4'd2, 32'd7, 32'd0);
        do_div(4'd1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div(4'd1, -32'sd9, 32'd0);
        do_div(4'd2, 32'd3, 32'd5);
        do_div(4'd1, -32'sd3, 32'd5);

        do_mv(4'd8, 32'h1234);
        do_mv(4'd9, 32'h5678);
        set(4'd1, 1'b1, 32'd100, 32'd7);
        step();
        en = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy", busy, 1);
        step();
        flush = 1'b0;
        chk_idle("flush_abort");
        do_mv(4'd9, 32'h55);

        set(4'd2, 1'b1, 32'd100, 32'd3);
        step();
        en = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        chk_idle("rst_mid_div");

        for (int k = 0; k < 60; k++) begin
            ro = 4'($urandom_range(1, 9));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 3) == 0) rx = $urandom_range(0, 20);
            if ($urandom_range(0, 3) == 0) ry = $urandom_range(0, 20);
            if ($urandom_range(0, 7) == 0) ry = 32'd0;
            if (ro inside {[4'd1:4'd2]}) do_div(ro, rx, ry);
            else if (ro inside {[4'd3:4'd5]}) do_mul(ro, rx, ry);
            else do_mv(ro, rx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit controller for the EX stage. It accepts the 4-bit mdu_op code produced by ID and sequences multi-cycle MULT/MULTU/MUL/DIV/DIVU operations. It owns the architectural HI/LO registers, serves MFHI/MFLO/MTHI/MTLO, and raises a pipeline stall while a dependent operation must wait.

Parameters:
MUL_CYCLES, 3, multiply latency in cycles after acceptance; legal range is 1..8.

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
mdu_op_i  in  4  0 none, 1 DIV, 2 DIVU, 3 MUL, 4 MULT, 5 MULTU, 6 MFHI, 7 MFLO, 8 MTHI, 9 MTLO; codes 10..15 are treated as none
mdu_en_i  in  1  EX instruction valid (not bubble); qualifies mdu_op_i
a_i  in  32  rs operand
b_i  in  32  rt operand
flush_i  in  1  exception/pipeline flush
stall_o  out  1  hold EX and upstream stages
busy_o  out  1  a multiply or divide is in flight
result_o  out  32  GPR write data for MFHI/MFLO/MUL
hi_o  out  32  HI register
lo_o  out  32  LO register

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous and active-low. Reset clears HI, LO, counters and operand registers, and forces state to IDLE. Reset mid-operation discards the operation.
- Outputs after reset: stall_o=0, busy_o=0, result_o=0, hi_o=0, lo_o=0.
- States: IDLE, MUL_BUSY, DIV_BUSY, DIV_SIGN.
- Acceptance: an op is accepted only in IDLE with mdu_en_i=1 and flush_i=0 (acceptance cycle = T).
- Any op 1..9 presented while not IDLE: stall_o=1 and the op is not accepted. This includes MFHI/MFLO/MTHI/MTLO (RAW/WAW on HI/LO).
- MTHI/MTLO in IDLE: HI/LO loaded with a_i at the end of T; no stall.
- MFHI/MFLO in IDLE: result_o = hi/lo combinationally in T; no stall. A same-cycle HI/LO write is not bypassed.
- MULT/MULTU (non-blocking):
  - Signed/unsigned 64-bit product is registered at T; state MUL_BUSY; counter loaded to MUL_CYCLES-1.
  - stall_o=0 in T; busy_o=1 in T+1..T+MUL_CYCLES.
  - {HI,LO} written at the end of T+MUL_CYCLES; state returns to IDLE on the same edge.
  - MUL_CYCLES=1: the product is written at the end of T+1.
- MUL (blocking):
  - Same sequencing as MULT (signed).
  - stall_o=1 in T..T+MUL_CYCLES-1.
  - In T+MUL_CYCLES: stall_o=0 and result_o = product[31:0]. The held MUL is consumed, not re-accepted.
  - HI/LO are unchanged.
- DIV/DIVU:
  - At T, latch |a|, |b| and the signs (magnitudes are the raw values for DIVU); state DIV_BUSY; counter = 32.
  - Restoring radix-2 division, one quotient bit per cycle in T+1..T+32.
  - DIV_SIGN in T+33 applies signs: quotient sign = sa^sb, remainder sign = sa.
  - LO=quotient and HI=remainder are written at the end of T+33.
  - busy_o=1 in T+1..T+33; stall_o=0 in T.
- Divide by zero: no exception and no special case; the algorithm result is used. Unsigned result: Q=0xFFFFFFFF, R=a; signed results then receive sign fixup.
- 0x80000000 / -1 (DIV): LO=0x80000000, HI=0.
- flush_i:
  - In IDLE, suppresses acceptance.
  - In any busy state, aborts: state goes to IDLE at the next edge and HI/LO are unchanged.
  - flush_i in the completion cycle suppresses the HI/LO write.
- result_o is 0 whenever it is not driven by MFHI/MFLO/MUL completion.

Optional Feature:
MDU_DIV_EARLY_EN
- Defined: DIV/DIVU with b≠0 and |a|<|b| skips DIV_BUSY. T+1 is DIV_SIGN, which writes Q=0 and R=a (signed remainder unchanged); busy_o is high for T+1 only.
- Undefined: every divide takes 33 busy cycles as above.

Test Plan:
MULTU a=0xFFFFFFFF b=2, then MFHI at T+1 -> stall_o high T+1..T+3; HI=0x00000001, LO=0xFFFFFFFE; MFHI result_o=1 in T+4.
MULT a=0xFFFFFFFF b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE at the end of T+3.
MUL a=6 b=7 -> stall_o high T..T+2; result_o=42 with stall_o=0 in T+3; HI/LO unchanged.
DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF at the end of T+33; DIVU a=7 b=0 -> LO=0xFFFFFFFF, HI=7.
DIV in flight, flush_i at T+10 -> IDLE at T+11; HI/LO keep their prior values; a new MTLO 0x55 at T+11 -> LO=0x55.
rst_n low at T+5 of a DIVU -> next cycle busy_o=0, HI=LO=0; with MDU_DIV_EARLY_EN, DIVU 3/5 -> LO=0, HI=3 at the end of T+1.
